// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 4:1 mux: drives a data pattern, steps
// the select through all four channels and captures/compares the output.
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] data_in,
    input  logic       mux_out,
    output logic [3:0] mux_data,
    output logic [1:0] sel,
    output logic [3:0] result,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [3:0] LAST = 4'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] mux_data_q, mux_data_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] result_q, result_d;
    logic       error_q, error_d;

    always_comb begin
        state_d    = state_q;
        mux_data_d = mux_data_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        error_d    = error_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mux_data_d = data_in;
                    sel_d      = 2'd0;
                    cnt_d      = 4'd0;
                    result_d   = 4'd0;
                    error_d    = 1'b0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (cnt_q == LAST) begin
                    result_d[sel_q] = mux_out;
                    cnt_d           = 4'd0;
                    sel_d           = sel_q + 2'd1;
                    if (sel_q == 2'd3) begin
                        // compare includes the bit captured on this edge
                        error_d = (result_d != mux_data_q);
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mux_data_q <= 4'd0;
            sel_q      <= 2'd0;
            cnt_q      <= 4'd0;
            result_q   <= 4'd0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mux_data_q <= mux_data_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            error_q    <= error_d;
        end
    end

    assign mux_data = mux_data_q;
    assign sel      = sel_q;
    assign result   = result_q;
    assign error    = error_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 4:1 mux downstream
// and a scoreboard of expected scan results.
`timescale 1ns/100ps
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st_a, st_b;
    logic [3:0] din;
    logic       stuck;

    logic [3:0] md_a, md_b, res_a, res_b;
    logic [1:0] sel_a, sel_b;
    logic       busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic       mo_a, mo_b;

    always #5 clk = ~clk;

    // downstream 4:1 muxes; instance A can be forced stuck at 0
    assign mo_a = stuck ? 1'b0 : md_a[sel_a];
    assign mo_b = md_b[sel_b];

    mux_scan_ctrl #(.DWELL(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(st_a), .data_in(din),
        .mux_out(mo_a), .mux_data(md_a), .sel(sel_a), .result(res_a),
        .busy(busy_a), .done(done_a), .error(err_a)
    );

    mux_scan_ctrl #(.DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(st_b), .data_in(din),
        .mux_out(mo_b), .mux_data(md_b), .sel(sel_b), .result(res_b),
        .busy(busy_b), .done(done_b), .error(err_b)
    );

    int which;
    logic [3:0] o_md, o_res;
    logic [1:0] o_sel;
    logic       o_busy, o_done, o_err;
    assign o_md   = which ? md_b   : md_a;
    assign o_res  = which ? res_b  : res_a;
    assign o_sel  = which ? sel_b  : sel_a;
    assign o_busy = which ? busy_b : busy_a;
    assign o_done = which ? done_b : done_a;
    assign o_err  = which ? err_b  : err_a;

    typedef struct {
        logic [3:0] res;
        logic       err;
        logic [3:0] md;
    } exp_t;
    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after start is driven; cycle 0 is the negedge after the
    // start edge. done must appear at cycle 4*dw.
    task automatic wait_done(input int dw, input bit drop, input bit poke);
        int   cyc;
        bit   seen;
        exp_t e;
        seen = 0;
        for (cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (drop && cyc == 0) begin st_a = 1'b0; st_b = 1'b0; end
            if (poke && cyc == 2) begin st_a = 1'b1; din = 4'b0001; end
            if (poke && cyc == 3) st_a = 1'b0;
            if (o_done) begin seen = 1; break; end
            chk("busy_scan", 16'(o_busy), 16'd1);
            chk("sel_seq", 16'(o_sel), 16'((cyc / dw) % 4));
            if (sb.size() > 0) chk("mux_data_hold", 16'(o_md), 16'(sb[0].md));
        end
        chk("done_seen", 16'(seen), 16'd1);
        chk("done_latency", 16'(cyc), 16'(4 * dw));
        if (sb.size() == 0) begin
            chk("sb_empty", 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            chk("result", 16'(o_res), 16'(e.res));
            chk("error", 16'(o_err), 16'(e.err));
            chk("busy_done", 16'(o_busy), 16'd1);
            chk("sel_wrap", 16'(o_sel), 16'd0);
        end
    endtask

    initial begin
        int ndone;
        which = 0;
        stuck = 1'b0;
        st_a  = 1'b0;
        st_b  = 1'b0;
        din   = 4'd0;
        rst_n = 1'b0;
        #1;
        chk("reset_a", 16'({md_a, sel_a, res_a, busy_a, done_a, err_a}), 16'd0);
        chk("reset_b", 16'({md_b, sel_b, res_b, busy_b, done_b, err_b}), 16'd0);

        // good mux, DWELL=2, start on the first edge after reset release
        @(negedge clk);
        rst_n = 1'b1;
        din   = 4'b1010;
        st_a  = 1'b1;
        sb.push_back('{res: 4'b1010, err: 1'b0, md: 4'b1010});
        wait_done(2, 1, 0);
        @(negedge clk);
        chk("idle_after", 16'({o_busy, o_done, o_err}), 16'd0);

        // stuck-at-0 mux: error raised with done and held in IDLE
        stuck = 1'b1;
        din   = 4'b0110;
        st_a  = 1'b1;
        sb.push_back('{res: 4'b0000, err: 1'b1, md: 4'b0110});
        wait_done(2, 1, 0);
        repeat (3) @(negedge clk);
        chk("err_hold", 16'({o_busy, o_done, o_err}), 16'b001);
        stuck = 1'b0;

        // start with other data mid-scan is ignored; error clears on start
        din  = 4'b0011;
        st_a = 1'b1;
        sb.push_back('{res: 4'b0011, err: 1'b0, md: 4'b0011});
        wait_done(2, 1, 1);
        @(negedge clk);
        chk("md_after_poke", 16'(o_md), 16'b0011);

        // async reset pulse mid-scan aborts with no done
        din  = 4'b1100;
        st_a = 1'b1;
        @(negedge clk);
        st_a = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #0.5;
        chk("async_rst", 16'({md_a, sel_a, res_a, busy_a, done_a, err_a}), 16'd0);
        #0.5 rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        chk("no_done_abort", 16'(ndone), 16'd0);
        chk("idle_abort", 16'(busy_a), 16'd0);

        din  = 4'b0101;
        st_a = 1'b1;
        sb.push_back('{res: 4'b0101, err: 1'b0, md: 4'b0101});
        wait_done(2, 1, 0);

        // DWELL=1, start held high: back-to-back scans via one IDLE cycle
        @(negedge clk);
        which = 1;
        din   = 4'b1111;
        st_b  = 1'b1;
        repeat (3) sb.push_back('{res: 4'b1111, err: 1'b0, md: 4'b1111});
        wait_done(1, 0, 0);
        repeat (2) begin
            @(negedge clk);
            chk("b2b_idle", 16'({o_busy, o_done}), 16'd0);
            wait_done(1, 0, 0);
        end
        st_b = 1'b0;
        chk("sb_drained", 16'(sb.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
